// File: rtl/resp_misr_pkg.sv
// Shared types and constants for the response MISR compactor.
package resp_misr_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CAPT = 2'd1,
        CMP  = 2'd2
    } state_t;

    localparam logic [15:0] DEFAULT_POLY = 16'h1021;

    // RESP bit positions of the CUT primary outputs
    localparam int G147_BIT = 0;
    localparam int G148_BIT = 1;
    localparam int G198_BIT = 2;
    localparam int G199_BIT = 3;
    localparam int G213_BIT = 4;
    localparam int G214_BIT = 5;

endpackage

// File: rtl/resp_misr_core.sv
// Combinational next-signature step: shift left, fold the MSB back through
// POLY, and XOR the response into the low bits.
module misr_core #(
    parameter int               SIG_W  = 16,
    parameter int               RESP_W = 6,
    parameter logic [SIG_W-1:0] POLY   = 16'h1021
) (
    input  logic [SIG_W-1:0]  sig,
    input  logic [RESP_W-1:0] resp,
    output logic [SIG_W-1:0]  sig_next
);

    always_comb begin
        sig_next = {sig[SIG_W-2:0], 1'b0}
                 ^ (sig[SIG_W-1] ? POLY : '0)
                 ^ SIG_W'(resp);
    end

endmodule

// File: rtl/resp_misr.sv
// Response compactor: folds valid CUT responses into a MISR over a programmed
// window, then compares against a golden signature and pulses DONE.
module resp_misr
    import resp_misr_pkg::*;
#(
    parameter int               SIG_W  = 16,
    parameter int               RESP_W = 6,
    parameter int               CNT_W  = 16,
    parameter logic [SIG_W-1:0] POLY   = DEFAULT_POLY
) (
    input  logic              CK,
    input  logic              RSTN,
    input  logic              START,
    input  logic [CNT_W-1:0]  NCYC,
    input  logic [SIG_W-1:0]  SEED,
    input  logic [SIG_W-1:0]  GOLDEN,
    input  logic [RESP_W-1:0] RESP,
    input  logic              RESP_VLD,
    output logic              BUSY,
    output logic              DONE,
    output logic              PASS,
    output logic [SIG_W-1:0]  SIG
);

    state_t           state;
    logic [CNT_W-1:0] cnt;
    logic [SIG_W-1:0] sig_next;

    misr_core #(
        .SIG_W  (SIG_W),
        .RESP_W (RESP_W),
        .POLY   (POLY)
    ) u_core (
        .sig      (SIG),
        .resp     (RESP),
        .sig_next (sig_next)
    );

    always_ff @(posedge CK) begin
        if (!RSTN) begin
            state <= IDLE;
            cnt   <= '0;
            SIG   <= '0;
            BUSY  <= 1'b0;
            DONE  <= 1'b0;
            PASS  <= 1'b0;
        end else begin
            DONE <= 1'b0;
            case (state)
                IDLE: begin
                    if (START) begin
                        SIG   <= SEED;
                        cnt   <= NCYC;
                        PASS  <= 1'b0;
                        BUSY  <= 1'b1;
                        state <= (NCYC != '0) ? CAPT : CMP;
                    end
                end
                CAPT: begin
                    // cnt is never zero here, so the decrement cannot wrap
                    if (RESP_VLD) begin
                        SIG <= sig_next;
                        cnt <= cnt - CNT_W'(1);
                        if (cnt == CNT_W'(1)) begin
                            state <= CMP;
                        end
                    end
                end
                CMP: begin
                    PASS  <= (SIG == GOLDEN);
                    DONE  <= 1'b1;
                    BUSY  <= 1'b0;
                    state <= IDLE;
                end
                default: begin
                    BUSY  <= 1'b0;
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_resp_misr.sv
// Self-checking bench for resp_misr: directed scenarios plus random traffic
// against a run-level behavioural model.
module tb_resp_misr;

    logic        CK = 1'b0;
    logic        RSTN;
    logic        START;
    logic [15:0] NCYC;
    logic [15:0] SEED;
    logic [15:0] GOLDEN;
    logic [5:0]  RESP;
    logic        RESP_VLD;
    logic        BUSY;
    logic        DONE;
    logic        PASS;
    logic [15:0] SIG;

    always #5 CK = ~CK;

    resp_misr dut (
        .CK       (CK),
        .RSTN     (RSTN),
        .START    (START),
        .NCYC     (NCYC),
        .SEED     (SEED),
        .GOLDEN   (GOLDEN),
        .RESP     (RESP),
        .RESP_VLD (RESP_VLD),
        .BUSY     (BUSY),
        .DONE     (DONE),
        .PASS     (PASS),
        .SIG      (SIG)
    );

    int n_vec  = 0;
    int n_fail = 0;

    // Model: a run is either absent, collecting m_left more responses, or
    // waiting its single compare cycle.
    logic [15:0] m_sig  = '0;
    logic        m_pass = 1'b0;
    logic        m_done = 1'b0;
    logic        m_busy = 1'b0;
    logic        m_cmp  = 1'b0;
    int          m_left = 0;

    function automatic logic [15:0] ref_misr(input logic [15:0] s, input logic [5:0] r);
        logic [15:0] n;
        logic [15:0] p;
        logic [15:0] rr;
        p  = 16'h1021;
        rr = {10'b0, r};
        for (int i = 0; i < 16; i++) begin
            n[i] = ((i > 0) ? s[i-1] : 1'b0) ^ (s[15] & p[i]) ^ rr[i];
        end
        return n;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_step();
        logic nd;
        nd = 1'b0;
        if (!RSTN) begin
            m_sig  = '0;
            m_pass = 1'b0;
            m_busy = 1'b0;
            m_cmp  = 1'b0;
            m_left = 0;
        end else if (!m_busy) begin
            if (START) begin
                m_sig  = SEED;
                m_pass = 1'b0;
                m_left = int'(NCYC);
                m_busy = 1'b1;
                m_cmp  = (NCYC == 16'd0);
            end
        end else if (m_cmp) begin
            m_pass = (m_sig == GOLDEN);
            nd     = 1'b1;
            m_busy = 1'b0;
            m_cmp  = 1'b0;
        end else if (RESP_VLD) begin
            m_sig  = ref_misr(m_sig, RESP);
            m_left = m_left - 1;
            if (m_left == 0) m_cmp = 1'b1;
        end
        m_done = nd;
    endtask

    // One clock: advance the model on the edge, compare just after it.
    task automatic cycle();
        @(posedge CK);
        model_step();
        #1;
        check("sig",  32'(SIG),  32'(m_sig));
        check("busy", 32'(BUSY), 32'(m_busy));
        check("done", 32'(DONE), 32'(m_done));
        check("pass", 32'(PASS), 32'(m_pass));
    endtask

    task automatic start_run(input logic [15:0] seed, input logic [15:0] n, input logic [15:0] gold);
        START    = 1'b1;
        SEED     = seed;
        NCYC     = n;
        GOLDEN   = gold;
        RESP_VLD = 1'b0;
        cycle();
        START    = 1'b0;
    endtask

    task automatic feed(input logic [5:0] r, input logic v);
        RESP     = r;
        RESP_VLD = v;
        cycle();
        RESP_VLD = 1'b0;
    endtask

    task automatic wait_done(input int budget);
        int k;
        k = 0;
        while (DONE !== 1'b1 && k < budget) begin
            cycle();
            k++;
        end
        if (DONE !== 1'b1) check("done_timeout", 32'(DONE), 32'd1);
    endtask

    logic [5:0]  r1, r2, r3;
    logic [15:0] sig_stall;

    initial begin
        RSTN = 1'b0; START = 1'b0; NCYC = '0; SEED = '0; GOLDEN = '0;
        RESP = '0; RESP_VLD = 1'b0;

        // Pin the model's MISR step with hand-computed values
        check("ref_0_1",    32'(ref_misr(16'h0000, 6'd1)), 32'h0001);
        check("ref_1_1",    32'(ref_misr(16'h0001, 6'd1)), 32'h0003);
        check("ref_8000_0", 32'(ref_misr(16'h8000, 6'd0)), 32'h1021);

        cycle(); cycle();
        check("rst_sig",  32'(SIG),  32'h0);
        check("rst_busy", 32'(BUSY), 32'h0);
        check("rst_done", 32'(DONE), 32'h0);
        check("rst_pass", 32'(PASS), 32'h0);
        RSTN = 1'b1;
        cycle();

        // Basic capture, matching and mismatching golden
        start_run(16'h0000, 16'd1, 16'h0001);
        feed(6'b000001, 1'b1);
        check("basic_sig", 32'(SIG), 32'h0001);
        cycle();
        check("basic_done", 32'(DONE), 32'd1);
        check("basic_pass", 32'(PASS), 32'd1);
        start_run(16'h0000, 16'd1, 16'h0000);
        feed(6'b000001, 1'b1);
        cycle();
        check("basic_done2", 32'(DONE), 32'd1);
        check("basic_fail",  32'(PASS), 32'd0);
        cycle();
        check("done_pulse", 32'(DONE), 32'd0);

        // Shift and feedback
        start_run(16'h0000, 16'd2, 16'h0000);
        feed(6'd1, 1'b1);
        feed(6'd1, 1'b1);
        check("shift_sig", 32'(SIG), 32'h0003);
        wait_done(4);
        start_run(16'h8000, 16'd1, 16'h1021);
        feed(6'd0, 1'b1);
        check("fb_sig", 32'(SIG), 32'h1021);
        cycle();
        check("fb_pass", 32'(PASS), 32'd1);

        // Stalls
        r1 = 6'($urandom); r2 = 6'($urandom); r3 = 6'($urandom);
        start_run(16'h1234, 16'd3, 16'h0000);
        feed(r1, 1'b1); feed(6'h3f, 1'b0); feed(6'h3f, 1'b0);
        feed(r2, 1'b1); feed(6'h3f, 1'b0); feed(r3, 1'b1);
        check("stall_nodone", 32'(DONE), 32'd0);
        cycle();
        check("stall_done", 32'(DONE), 32'd1);
        sig_stall = SIG;
        check("stall_sig", 32'(sig_stall), 32'(ref_misr(ref_misr(ref_misr(16'h1234, r1), r2), r3)));
        start_run(16'h1234, 16'd3, 16'h0000);
        feed(r1, 1'b1); feed(r2, 1'b1); feed(r3, 1'b1);
        cycle();
        check("nostall_sig", 32'(SIG), 32'(sig_stall));

        // Zero window
        start_run(16'hBEEF, 16'd0, 16'hBEEF);
        check("zero_busy", 32'(BUSY), 32'd1);
        cycle();
        check("zero_done", 32'(DONE), 32'd1);
        check("zero_pass", 32'(PASS), 32'd1);
        check("zero_sig",  32'(SIG),  32'hBEEF);
        check("zero_idle", 32'(BUSY), 32'd0);

        // START while busy is ignored; START in the DONE cycle is accepted
        start_run(16'h0000, 16'd2, 16'h0003);
        feed(6'd1, 1'b1);
        START = 1'b1; SEED = 16'hFFFF; NCYC = 16'd7;
        cycle();
        START = 1'b0;
        feed(6'd1, 1'b1);
        check("busy_start_sig", 32'(SIG), 32'h0003);
        cycle();
        check("busy_start_pass", 32'(PASS), 32'd1);
        start_run(16'h8000, 16'd1, 16'h1021);
        check("b2b_busy", 32'(BUSY), 32'd1);
        check("b2b_sig",  32'(SIG),  32'h8000);
        feed(6'd0, 1'b1);
        cycle();
        check("b2b_pass", 32'(PASS), 32'd1);

        // Reset mid-run
        start_run(16'h5555, 16'd5, 16'h0000);
        feed(6'h2a, 1'b1); feed(6'h15, 1'b1);
        RSTN = 1'b0;
        cycle();
        check("mid_rst_sig",  32'(SIG),  32'h0);
        check("mid_rst_busy", 32'(BUSY), 32'd0);
        check("mid_rst_pass", 32'(PASS), 32'd0);
        check("mid_rst_done", 32'(DONE), 32'd0);
        RSTN = 1'b1;
        cycle();
        start_run(16'h0000, 16'd1, 16'h0001);
        feed(6'b000001, 1'b1);
        wait_done(3);
        check("post_rst_sig",  32'(SIG),  32'h0001);
        check("post_rst_pass", 32'(PASS), 32'd1);

        // Random traffic
        for (int c = 0; c < 3000; c++) begin
            RSTN     = ($urandom_range(0, 249) != 0);
            START    = ($urandom_range(0, 5) == 0);
            NCYC     = 16'($urandom_range(0, 6));
            SEED     = 16'($urandom);
            RESP     = 6'($urandom);
            RESP_VLD = ($urandom_range(0, 2) != 0);
            GOLDEN   = (m_cmp && $urandom_range(0, 1) == 1) ? m_sig : 16'($urandom);
            cycle();
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule
